rx_frame_buffer: RTL and testbench
==================================

# rx_frame_buffer

Packet-buffer write stage in the `switch_clk` domain, directly downstream of the RX MAC control block. It accepts the byte stream and frame markers, stores each frame into a circular byte RAM, and commits a descriptor (start address, length, MACs) only for good frames. Bad, runt and oversized frames, and frames arriving with no buffer space, are dropped by rewinding the write pointer. Downstream lookup/forwarding logic pops descriptors, reads frame bytes by address and frees space in order.

## Interface
- DATA_WIDTH, 8, byte width (package constant)
- BUF_DEPTH, 4096, RAM bytes; power of two; ADDR_W = $clog2(BUF_DEPTH)
- DESC_DEPTH, 16, descriptor FIFO entries; power of two
- MIN_FRAME_LEN, 64, minimum length incl. FCS
- MAX_FRAME_LEN, 1522, maximum length incl. FCS; LEN_W = 11
- switch_clk  in  1  sole clock
- switch_rst_n  in  1  reset, asynchronous, active-low
- frame_data_i  in  DATA_WIDTH  frame byte
- frame_valid_i  in  1  byte transferred when frame_valid_i && frame_grant_o
- frame_sof_i  in  1  single-cycle start pulse
- frame_eof_i  in  1  single-cycle end pulse
- frame_error_i  in  1  sampled in eof cycle; 1 = bad frame
- frame_grant_o  out  1  backpressure to upstream
- mac_dst_addr_i, mac_src_addr_i  in  [5:0][7:0]  sampled in eof cycle
- desc_valid_o / desc_ready_i  out/in  1  descriptor handshake; pop on both high
- desc_start_addr_o  out  ADDR_W  first byte address
- desc_len_o  out  LEN_W  byte count
- desc_dst_mac_o, desc_src_mac_o  out  [5:0][7:0]
- rd_addr_i  in  ADDR_W;  rd_data_o  out  DATA_WIDTH  registered, 1-cycle latency
- free_i  in  1;  free_len_i  in  LEN_W  release oldest committed frame
- frames_committed_o, frames_dropped_o  out  16  saturating counters

## Operation
- Pointers wr_ptr, commit_ptr, tail_ptr are ADDR_W+1 bits, wrapping mod 2·BUF_DEPTH. Used = commit_ptr − tail_ptr; free = BUF_DEPTH − used.
- IDLE: valid bytes ignored. On sof: if free ≥ MAX_FRAME_LEN and descriptor slots (committed + pending) < DESC_DEPTH, go to WRITE with wr_ptr = commit_ptr and len = 0. Otherwise go to DROP.
- WRITE: each accepted byte is written at wr_ptr[ADDR_W-1:0], then wr_ptr++ and len++. No byte is written in the eof cycle.
  - If len would exceed MAX_FRAME_LEN, the byte is discarded and the state becomes DROP (oversize).
- eof in WRITE: if error_i=1 or len < MIN_FRAME_LEN, rewind (wr_ptr = commit_ptr), count a drop and go to IDLE. Otherwise latch the MACs and go to COMMIT.
- COMMIT (1 cycle): push {commit_ptr, len, MACs}, set commit_ptr = wr_ptr, count a commit, go to IDLE.
- DROP: discard bytes. On eof, rewind, count a drop (one drop per frame) and go to IDLE.
- sof in WRITE/DROP (no preceding eof): abort the current frame (rewind, count a drop), then apply the IDLE sof rule in the same cycle.
- frame_grant_o = 0 only in COMMIT; otherwise 1.
- free_i: tail_ptr += free_len_i. Occurs in any state, including simultaneously with COMMIT; the free value seen at a sof uses registered pointers.
- Descriptor FIFO: `desc_valid_o` = FIFO non-empty. A simultaneous push and pop is legal. A push into a full FIFO cannot occur because the slot is reserved at sof.
- Counters saturate at 16'hFFFF.
- Reset: state IDLE, all pointers 0, FIFO empty, desc_valid_o 0, desc_* outputs 0, rd_data_o 0, counters 0, frame_grant_o 1. A frame in progress at reset is lost. RAM contents are not reset.

## Timing
- RAM write occurs in the same edge as byte acceptance. A read at rd_addr_i in cycle T returns data at T+1. A read of the address being written in the same cycle returns the old data.
- eof at cycle T → COMMIT at T+1 (grant low) → desc_valid_o high at T+2 (if the FIFO was empty). Drop counters update at T+1.
- Single-cycle sof/eof pulses only. A simultaneous sof and eof is treated as eof first, then sof.

## Structure
- Shared package: DATA_WIDTH, MIN_FRAME_LEN, MAX_FRAME_LEN, LEN_W, `state_t {IDLE, WRITE, DROP, COMMIT}`, `rx_desc_t` struct (start, len, dst, src).
- One sub-module, `frame_ram`: simple dual-port RAM with one write port and one synchronous read port. The descriptor FIFO and pointer logic are inline.

## Test plan
- 64-byte frame, bytes 0x00–0x3F, error 0 → desc at eof+2: start 0, len 64, dst = 00:01:02:03:04:05. Reads at 0..63 return 0x00–0x3F. frames_committed_o = 1.
- 100-byte frame with frame_error_i=1 at eof → no descriptor, frames_dropped_o = 1. Next good frame gets start 0.
- 60-byte runt → dropped. 1523-byte frame → DROP on byte 1523, no descriptor, wr_ptr rewound.
- BUF_DEPTH 4096, three 1518-byte frames with no frees → third dropped at sof (free 1060 < 1522). Then free_i with 1518 → next frame committed at start 3036.
- Wrap: tail/commit at 4000, 200-byte frame → desc start 4000, len 200. Bytes 96..199 are stored at addresses 0..103 and read back correctly.
- desc_ready_i held low and 16 frames committed → 17th dropped at sof. A sof mid-frame aborts the first frame (one drop) and accepts the second. Reset asserted mid-WRITE clears all pointers and outputs to 0.

Source files
------------

// File: rtl/rx_frame_buffer_pkg.sv
// Shared constants, state encoding and descriptor layout for the RX frame buffer.
package rx_frame_buffer_pkg;

   localparam int DATA_WIDTH    = 8;
   localparam int BUF_DEPTH     = 4096;
   localparam int ADDR_W        = $clog2(BUF_DEPTH);
   localparam int DESC_DEPTH    = 16;
   localparam int DESC_AW       = $clog2(DESC_DEPTH);
   localparam int MIN_FRAME_LEN = 64;
   localparam int MAX_FRAME_LEN = 1522;
   localparam int LEN_W         = 11;
   localparam int CNT_W         = 16;

   typedef enum logic [1:0] {IDLE, WRITE, DROP, COMMIT} state_t;

   typedef logic [5:0][7:0] mac_t;

   typedef struct packed {
      logic [ADDR_W-1:0] start;
      logic [LEN_W-1:0]  len;
      mac_t              dst;
      mac_t              src;
   } rx_desc_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/rx_frame_buffer_if.sv
// Frame stream from the RX MAC plus the descriptor handshake toward lookup logic.
interface rx_frame_buffer_if;
   import rx_frame_buffer_pkg::*;

   logic [DATA_WIDTH-1:0] frame_data_i;
   logic                  frame_valid_i;
   logic                  frame_sof_i;
   logic                  frame_eof_i;
   logic                  frame_error_i;
   logic                  frame_grant_o;
   mac_t                  mac_dst_addr_i;
   mac_t                  mac_src_addr_i;

   logic                  desc_valid_o;
   logic                  desc_ready_i;
   logic [ADDR_W-1:0]     desc_start_addr_o;
   logic [LEN_W-1:0]      desc_len_o;
   mac_t                  desc_dst_mac_o;
   mac_t                  desc_src_mac_o;

   modport master (
      output frame_data_i, frame_valid_i, frame_sof_i, frame_eof_i, frame_error_i,
      output mac_dst_addr_i, mac_src_addr_i, desc_ready_i,
      input  frame_grant_o, desc_valid_o, desc_start_addr_o, desc_len_o,
      input  desc_dst_mac_o, desc_src_mac_o
   );

   modport slave (
      input  frame_data_i, frame_valid_i, frame_sof_i, frame_eof_i, frame_error_i,
      input  mac_dst_addr_i, mac_src_addr_i, desc_ready_i,
      output frame_grant_o, desc_valid_o, desc_start_addr_o, desc_len_o,
      output desc_dst_mac_o, desc_src_mac_o
   );

endinterface

// File: rtl/rx_frame_buffer_frame_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port (read-old-data).
module rx_frame_buffer_frame_ram #(
   parameter int DW = 8,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Only the output register is reset; the array stays a plain block RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/rx_frame_buffer.sv
// Writes received frames into a circular byte buffer and commits descriptors for good frames;
// bad, short, oversized or unplaceable frames are discarded by rewinding the write pointer.
module rx_frame_buffer
   import rx_frame_buffer_pkg::*;
(
   input  logic                  switch_clk,
   input  logic                  switch_rst_n,
   rx_frame_buffer_if.slave      bus,
   input  logic [ADDR_W-1:0]     rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   input  logic                  free_i,
   input  logic [LEN_W-1:0]      free_len_i,
   output logic [CNT_W-1:0]      frames_committed_o,
   output logic [CNT_W-1:0]      frames_dropped_o
);

   localparam int PTR_W   = ADDR_W + 1;
   localparam int FIFO_CW = DESC_AW + 1;

   state_t            state_reg, state_next;
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  commit_ptr_reg, commit_ptr_next;
   logic [PTR_W-1:0]  tail_ptr_reg;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic              sof_pend_reg, sof_pend_next;
   mac_t              dst_reg, src_reg;
   logic [CNT_W-1:0]  committed_reg, dropped_reg;

   logic              ram_we;
   logic              push;
   logic              drop;
   logic              mac_latch;
   logic              take_sof;
   logic              grant;
   logic [PTR_W-1:0]  free_space;
   logic [PTR_W-1:0]  free_after_commit;
   logic              sof_ok;
   logic              sof_ok_post;

   rx_desc_t          fifo_mem [DESC_DEPTH];
   logic [FIFO_CW-1:0] fifo_wr_reg, fifo_rd_reg, fifo_count;
   logic              desc_valid;
   logic              pop;
   rx_desc_t          desc_in;
   rx_desc_t          head;

   assign free_space        = PTR_W'(BUF_DEPTH) - (commit_ptr_reg - tail_ptr_reg);
   assign free_after_commit = PTR_W'(BUF_DEPTH) - (wr_ptr_reg - tail_ptr_reg);
   assign fifo_count        = fifo_wr_reg - fifo_rd_reg;

   // Admission needs room for a worst-case frame and a descriptor slot reserved up front.
   assign sof_ok      = (free_space >= PTR_W'(MAX_FRAME_LEN)) &&
                        (fifo_count < FIFO_CW'(DESC_DEPTH));
   assign sof_ok_post = (free_after_commit >= PTR_W'(MAX_FRAME_LEN)) &&
                        ((fifo_count + FIFO_CW'(1)) < FIFO_CW'(DESC_DEPTH));

   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      wr_ptr_next     = wr_ptr_reg;
      commit_ptr_next = commit_ptr_reg;
      len_next        = len_reg;
      sof_pend_next   = 1'b0;
      ram_we          = 1'b0;
      push            = 1'b0;
      drop            = 1'b0;
      mac_latch       = 1'b0;
      take_sof        = 1'b0;
      grant           = 1'b1;

      unique case (state_reg)
         IDLE: begin
            take_sof = bus.frame_sof_i;
         end
         WRITE: begin
            if (bus.frame_eof_i) begin
               if (bus.frame_error_i || (len_reg < LEN_W'(MIN_FRAME_LEN))) begin
                  drop        = 1'b1;
                  wr_ptr_next = commit_ptr_reg;
                  state_next  = IDLE;
                  take_sof    = bus.frame_sof_i;
               end else begin
                  mac_latch     = 1'b1;
                  state_next    = COMMIT;
                  sof_pend_next = bus.frame_sof_i;
               end
            end else if (bus.frame_sof_i) begin
               drop     = 1'b1;
               take_sof = 1'b1;
            end else if (bus.frame_valid_i) begin
               if (len_reg == LEN_W'(MAX_FRAME_LEN)) begin
                  state_next = DROP;
               end else begin
                  ram_we      = 1'b1;
                  wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                  len_next    = len_reg + LEN_W'(1);
               end
            end
         end
         DROP: begin
            if (bus.frame_eof_i || bus.frame_sof_i) begin
               drop        = 1'b1;
               wr_ptr_next = commit_ptr_reg;
               state_next  = IDLE;
               take_sof    = bus.frame_sof_i;
            end
         end
         COMMIT: begin
            grant           = 1'b0;
            push            = 1'b1;
            commit_ptr_next = wr_ptr_reg;
            state_next      = IDLE;
            // A sof that arrived with the committing eof starts right after the commit.
            if (sof_pend_reg) begin
               len_next   = '0;
               state_next = sof_ok_post ? WRITE : DROP;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (take_sof) begin
         wr_ptr_next = commit_ptr_reg;
         len_next    = '0;
         state_next  = sof_ok ? WRITE : DROP;
      end
   end

   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         wr_ptr_reg     <= '0;
         commit_ptr_reg <= '0;
         tail_ptr_reg   <= '0;
         len_reg        <= '0;
         sof_pend_reg   <= 1'b0;
         dst_reg        <= '0;
         src_reg        <= '0;
         committed_reg  <= '0;
         dropped_reg    <= '0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         commit_ptr_reg <= commit_ptr_next;
         len_reg        <= len_next;
         sof_pend_reg   <= sof_pend_next;
         if (free_i) begin
            tail_ptr_reg <= tail_ptr_reg + PTR_W'(free_len_i);
         end
         if (mac_latch) begin
            dst_reg <= bus.mac_dst_addr_i;
            src_reg <= bus.mac_src_addr_i;
         end
         if (push) begin
            committed_reg <= sat_inc(committed_reg);
         end
         if (drop) begin
            dropped_reg <= sat_inc(dropped_reg);
         end
      end
   end

   assign desc_in = '{start: commit_ptr_reg[ADDR_W-1:0], len: len_reg, dst: dst_reg, src: src_reg};

   always_ff @(posedge switch_clk) begin
      if (push) begin
         fifo_mem[fifo_wr_reg[DESC_AW-1:0]] <= desc_in;
      end
   end

   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         fifo_wr_reg <= '0;
         fifo_rd_reg <= '0;
      end else begin
         if (push) begin
            fifo_wr_reg <= fifo_wr_reg + FIFO_CW'(1);
         end
         if (pop) begin
            fifo_rd_reg <= fifo_rd_reg + FIFO_CW'(1);
         end
      end
   end

   assign desc_valid = (fifo_count != '0);
   assign pop        = desc_valid && bus.desc_ready_i;
   assign head       = fifo_mem[fifo_rd_reg[DESC_AW-1:0]];

   // Outputs are forced to zero while empty so unwritten entries never leak out.
   assign bus.desc_valid_o      = desc_valid;
   assign bus.desc_start_addr_o = desc_valid ? head.start : '0;
   assign bus.desc_len_o        = desc_valid ? head.len   : '0;
   assign bus.desc_dst_mac_o    = desc_valid ? head.dst   : '0;
   assign bus.desc_src_mac_o    = desc_valid ? head.src   : '0;
   assign bus.frame_grant_o     = grant;

   assign frames_committed_o = committed_reg;
   assign frames_dropped_o   = dropped_reg;

   rx_frame_buffer_frame_ram #(
      .DW (DATA_WIDTH),
      .AW (ADDR_W)
   ) frame_ram (
      .clk     (switch_clk),
      .rst_n   (switch_rst_n),
      .we      (ram_we),
      .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
      .wr_data (bus.frame_data_i),
      .rd_addr (rd_addr_i),
      .rd_data (rd_data_o)
   );

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer with a frame-level reference model and per-cycle compare.
module tb_rx_frame_buffer;
   import rx_frame_buffer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rx_frame_buffer_if bus();

   logic [ADDR_W-1:0]     rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  free_i;
   logic [LEN_W-1:0]      free_len;
   logic [CNT_W-1:0]      n_commit;
   logic [CNT_W-1:0]      n_drop;

   rx_frame_buffer dut (
      .switch_clk         (clk),
      .switch_rst_n       (rst_n),
      .bus                (bus),
      .rd_addr_i          (rd_addr),
      .rd_data_o          (rd_data),
      .free_i             (free_i),
      .free_len_i         (free_len),
      .frames_committed_o (n_commit),
      .frames_dropped_o   (n_drop)
   );

   typedef struct {
      int          start;
      int          len;
      logic [47:0] dst;
      logic [47:0] src;
   } mdesc_t;

   mdesc_t      m_q[$];
   int          m_commit;
   int          m_tail;
   int          m_commits;
   int          m_drops;
   bit          m_in_frame;
   bit          exp_grant;
   logic [7:0]  m_mem [4096];
   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat16(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   function automatic logic [7:0] byte_of(input int seed, input int i);
      return 8'((seed + i) & 255);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison of every observable output against the model.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("grant", bus.frame_grant_o, exp_grant);
         chk("desc_valid", bus.desc_valid_o, m_q.size() != 0);
         if (m_q.size() != 0) begin
            chk("desc_start", bus.desc_start_addr_o, m_q[0].start);
            chk("desc_len", bus.desc_len_o, m_q[0].len);
            chk("desc_dst", bus.desc_dst_mac_o, m_q[0].dst);
            chk("desc_src", bus.desc_src_mac_o, m_q[0].src);
         end
         chk("committed", n_commit, m_commits);
         chk("dropped", n_drop, m_drops);
      end
   end

   task automatic clear_inputs();
      bus.frame_data_i   = '0;
      bus.frame_valid_i  = 1'b0;
      bus.frame_sof_i    = 1'b0;
      bus.frame_eof_i    = 1'b0;
      bus.frame_error_i  = 1'b0;
      bus.mac_dst_addr_i = '0;
      bus.mac_src_addr_i = '0;
      bus.desc_ready_i   = 1'b0;
      rd_addr            = '0;
      free_i             = 1'b0;
      free_len           = '0;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst_n  = 1'b0;
      clear_inputs();
      #2;
      chk("rst_desc_valid", bus.desc_valid_o, 0);
      chk("rst_desc_start", bus.desc_start_addr_o, 0);
      chk("rst_desc_len", bus.desc_len_o, 0);
      chk("rst_desc_dst", bus.desc_dst_mac_o, 0);
      chk("rst_desc_src", bus.desc_src_mac_o, 0);
      chk("rst_grant", bus.frame_grant_o, 1);
      chk("rst_committed", n_commit, 0);
      chk("rst_dropped", n_drop, 0);
      chk("rst_rd_data", rd_data, 0);
      m_q.delete();
      m_commit   = 0;
      m_tail     = 0;
      m_commits  = 0;
      m_drops    = 0;
      m_in_frame = 1'b0;
      exp_grant  = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk_en = 1'b1;
      $display("reset applied");
   endtask

   task automatic send_frame(input int n, input bit err, input logic [47:0] dst,
                             input logic [47:0] src, input int seed, input bit no_eof);
      bit     acc;
      bit     good;
      int     free_b;
      mdesc_t d;
      free_b = 4096 - (m_commit - m_tail);
      acc    = (free_b >= MAX_FRAME_LEN) && (m_q.size() < DESC_DEPTH);
      bus.frame_sof_i = 1'b1;
      step();
      bus.frame_sof_i = 1'b0;
      if (m_in_frame) m_drops = sat16(m_drops);
      m_in_frame = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.frame_valid_i = 1'b1;
         bus.frame_data_i  = byte_of(seed, i);
         step();
      end
      bus.frame_valid_i = 1'b0;
      if (no_eof) begin
         $display("frame len=%0d left open", n);
         return;
      end
      bus.frame_eof_i    = 1'b1;
      bus.frame_error_i  = err;
      bus.mac_dst_addr_i = dst;
      bus.mac_src_addr_i = src;
      step();
      bus.frame_eof_i    = 1'b0;
      bus.frame_error_i  = 1'b0;
      bus.mac_dst_addr_i = '0;
      bus.mac_src_addr_i = '0;
      m_in_frame = 1'b0;
      good = acc && !err && (n >= MIN_FRAME_LEN) && (n <= MAX_FRAME_LEN);
      if (!good) begin
         m_drops = sat16(m_drops);
      end else begin
         exp_grant = 1'b0;
         step();
         exp_grant = 1'b1;
         for (int i = 0; i < n; i++) m_mem[(m_commit + i) % 4096] = byte_of(seed, i);
         d.start = m_commit % 4096;
         d.len   = n;
         d.dst   = dst;
         d.src   = src;
         m_q.push_back(d);
         m_commit  += n;
         m_commits = sat16(m_commits);
      end
      $display("frame len=%0d err=%0b -> %s", n, err, good ? "committed" : "dropped");
   endtask

   task automatic pop_desc();
      mdesc_t d;
      bus.desc_ready_i = 1'b1;
      step();
      bus.desc_ready_i = 1'b0;
      d = m_q.pop_front();
      $display("pop desc start=%0d len=%0d", d.start, d.len);
   endtask

   task automatic do_free(input int n);
      free_i   = 1'b1;
      free_len = LEN_W'(n);
      step();
      free_i = 1'b0;
      m_tail += n;
      $display("free %0d bytes", n);
   endtask

   task automatic read_check(input int a);
      rd_addr = ADDR_W'(a);
      step();
      chk("rd_data", rd_data, m_mem[a]);
      $display("read addr=%0d data=%02h", a, rd_data);
   endtask

   initial begin
      clear_inputs();

      // Minimum-length good frame
      do_reset();
      send_frame(64, 1'b0, 48'h000102030405, 48'h0A0B0C0D0E0F, 0, 1'b0);
      chk("s1_start", bus.desc_start_addr_o, 0);
      chk("s1_len", bus.desc_len_o, 64);
      chk("s1_dst", bus.desc_dst_mac_o, 48'h000102030405);
      chk("s1_committed", n_commit, 1);
      for (int a = 0; a < 64; a++) read_check(a);
      chk("s1_lit_rd63", rd_data, 8'h3F);

      // Error, runt and oversize frames rewind the write pointer
      do_reset();
      send_frame(100, 1'b1, 48'h111111111111, 48'h222222222222, 5, 1'b0);
      chk("s2_dropped", n_drop, 1);
      chk("s2_no_desc", bus.desc_valid_o, 0);
      send_frame(64, 1'b0, 48'h333333333333, 48'h444444444444, 9, 1'b0);
      chk("s2_start0", bus.desc_start_addr_o, 0);
      send_frame(60, 1'b0, 48'h555555555555, 48'h666666666666, 1, 1'b0);
      send_frame(1523, 1'b0, 48'h777777777777, 48'h888888888888, 2, 1'b0);
      chk("s2_dropped3", n_drop, 3);
      pop_desc();
      send_frame(64, 1'b0, 48'h999999999999, 48'hAAAAAAAAAAAA, 3, 1'b0);
      chk("s2_start64", bus.desc_start_addr_o, 64);

      // Buffer exhaustion, then recovery after a free
      do_reset();
      send_frame(1518, 1'b0, 48'h010101010101, 48'h020202020202, 10, 1'b0);
      send_frame(1518, 1'b0, 48'h030303030303, 48'h040404040404, 20, 1'b0);
      send_frame(1518, 1'b0, 48'h050505050505, 48'h060606060606, 30, 1'b0);
      chk("s3_dropped", n_drop, 1);
      pop_desc();
      do_free(1518);
      send_frame(1518, 1'b0, 48'h070707070707, 48'h080808080808, 40, 1'b0);
      pop_desc();
      chk("s3_start3036", bus.desc_start_addr_o, 3036);
      read_check(0);
      read_check(457);
      read_check(3036);

      // Wrap across the end of the RAM
      do_reset();
      send_frame(1500, 1'b0, 48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 50, 1'b0);
      pop_desc();
      do_free(1500);
      send_frame(1500, 1'b0, 48'h0E0E0E0E0E0E, 48'h0F0F0F0F0F0F, 60, 1'b0);
      pop_desc();
      do_free(1500);
      send_frame(1000, 1'b0, 48'h101010101010, 48'h202020202020, 70, 1'b0);
      pop_desc();
      do_free(1000);
      send_frame(200, 1'b0, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 0, 1'b0);
      chk("s4_start", bus.desc_start_addr_o, 4000);
      chk("s4_len", bus.desc_len_o, 200);
      for (int a = 4000; a < 4096; a++) read_check(a);
      for (int a = 103; a >= 0; a--) read_check(a);
      chk("s4_lit_rd0", rd_data, 8'h60);

      // Descriptor FIFO full
      do_reset();
      for (int k = 0; k < 16; k++) send_frame(64, 1'b0, 48'(k), 48'(k + 100), k, 1'b0);
      send_frame(64, 1'b0, 48'hFEFEFEFEFEFE, 48'hEFEFEFEFEFEF, 99, 1'b0);
      chk("s5_committed", n_commit, 16);
      chk("s5_dropped", n_drop, 1);
      pop_desc();
      chk("s5_second_start", bus.desc_start_addr_o, 64);

      // sof mid-frame aborts the running frame
      do_reset();
      send_frame(40, 1'b0, '0, '0, 7, 1'b1);
      send_frame(64, 1'b0, 48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 11, 1'b0);
      chk("s6_dropped", n_drop, 1);
      chk("s6_committed", n_commit, 1);
      chk("s6_start", bus.desc_start_addr_o, 0);

      // Reset while a frame is being written
      send_frame(30, 1'b0, '0, '0, 12, 1'b1);
      do_reset();
      send_frame(64, 1'b0, 48'hE0E1E2E3E4E5, 48'hF0F1F2F3F4F5, 13, 1'b0);
      chk("s7_start", bus.desc_start_addr_o, 0);
      chk("s7_committed", n_commit, 1);
      read_check(0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
